// File: rtl/vreg_pkg.sv
// rtl/vreg_pkg.sv - shared defaults, derived widths and helpers for the vector register file
package vreg_pkg;

  localparam int NREGS_DEF  = 16;
  localparam int NELEMS_DEF = 16;
  localparam int EW_DEF     = 16;
  localparam int AW_DEF     = $clog2(NREGS_DEF);
  localparam int IW_DEF     = (NELEMS_DEF > 1) ? $clog2(NELEMS_DEF) : 1;
  localparam int LW_DEF     = $clog2(NELEMS_DEF + 1);
  localparam int VW_DEF     = NELEMS_DEF * EW_DEF;

  // Limit a requested length to the register capacity.
  function automatic int clamp_len(input int len, input int nelems);
    return (len > nelems) ? nelems : len;
  endfunction

  // Element index width; a single-element register still gets a 1-bit index.
  function automatic int idx_width(input int nelems);
    return (nelems > 1) ? $clog2(nelems) : 1;
  endfunction

endpackage

// File: rtl/vreg_next.sv
// rtl/vreg_next.sv - next data/length of one vector register from both write ports
module vreg_next
  import vreg_pkg::*;
#(
  parameter int NELEMS = NELEMS_DEF,
  parameter int EW     = EW_DEF,
  parameter int IW     = idx_width(NELEMS),
  parameter int LW     = $clog2(NELEMS + 1)
) (
  input  logic [NELEMS*EW-1:0] oldData,
  input  logic [LW-1:0]        oldLen,
  input  logic                 vwHit,
  input  logic [NELEMS*EW-1:0] vwData,
  input  logic [NELEMS-1:0]    vwMask,
  input  logic                 vwLenEn,
  input  logic [LW-1:0]        vwLen,
  input  logic                 swHit,
  input  logic [IW-1:0]        swInd,
  input  logic [EW-1:0]        swData,
  output logic [NELEMS*EW-1:0] newData,
  output logic [LW-1:0]        newLen
);

  logic          swValid;
  logic [LW-1:0] swLen;
  logic [LW-1:0] baseLen;

  // An out-of-range element index makes the element write a complete no-op.
  assign swValid = swHit && (int'(swInd) < NELEMS);
  assign swLen   = LW'(int'(swInd) + 1);

  // Element merge: the element write beats the masked vector write on its own index.
  always_comb begin
    newData = oldData;
    for (int i = 0; i < NELEMS; i++) begin
      if (swValid && (int'(swInd) == i)) begin
        newData[i*EW +: EW] = swData;
      end else if (vwHit && vwMask[i]) begin
        newData[i*EW +: EW] = vwData[i*EW +: EW];
      end
    end
  end

  // Length: optional clamped vector length first, then grow to cover the written element.
  always_comb begin
    baseLen = oldLen;
    if (vwHit && vwLenEn) begin
      baseLen = LW'(clamp_len(int'(vwLen), NELEMS));
    end
    newLen = baseLen;
    if (swValid && (swLen > baseLen)) begin
      newLen = swLen;
    end
  end

endmodule

// File: rtl/vreg_file.sv
// rtl/vreg_file.sv - vector register file with length and busy tracking per register
module vreg_file
  import vreg_pkg::*;
#(
  parameter int NREGS  = NREGS_DEF,
  parameter int NELEMS = NELEMS_DEF,
  parameter int EW     = EW_DEF,
  parameter int BYPASS = 0,
  parameter int AW     = $clog2(NREGS),
  parameter int IW     = idx_width(NELEMS),
  parameter int LW     = $clog2(NELEMS + 1),
  parameter int VW     = NELEMS * EW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [AW-1:0]     rAddr0,
  output logic [VW-1:0]     rData0,
  output logic [LW-1:0]     rLen0,
  input  logic [AW-1:0]     rAddr1,
  output logic [VW-1:0]     rData1,
  output logic [LW-1:0]     rLen1,
  input  logic [AW-1:0]     rAddr2,
  input  logic [IW-1:0]     rInd2,
  output logic [EW-1:0]     rData2,
  input  logic              vwEn,
  input  logic [AW-1:0]     vwAddr,
  input  logic [VW-1:0]     vwData,
  input  logic [NELEMS-1:0] vwMask,
  input  logic              vwLenEn,
  input  logic [LW-1:0]     vwLen,
  input  logic              swEn,
  input  logic [AW-1:0]     swAddr,
  input  logic [IW-1:0]     swInd,
  input  logic [EW-1:0]     swData,
  input  logic              busySet,
  input  logic [AW-1:0]     busySetAddr,
  input  logic              busyClr,
  input  logic [AW-1:0]     busyClrAddr,
  output logic [NREGS-1:0]  busy
);

  logic [VW-1:0]    regData  [NREGS];
  logic [LW-1:0]    regLen   [NREGS];
  logic [VW-1:0]    nextData [NREGS];
  logic [LW-1:0]    nextLen  [NREGS];
  logic [VW-1:0]    viewData [NREGS];
  logic [LW-1:0]    viewLen  [NREGS];
  logic [NREGS-1:0] busyReg;
  logic [NREGS-1:0] busyNext;
  logic [VW-1:0]    sel2;

  for (genvar r = 0; r < NREGS; r++) begin : gReg
    logic vwHit;
    logic swHit;

    // Requests in a reset cycle are dropped, so they never reach the merge.
    assign vwHit = vwEn && !reset && (int'(vwAddr) == r);
    assign swHit = swEn && !reset && (int'(swAddr) == r);

    vreg_next #(
      .NELEMS(NELEMS),
      .EW    (EW),
      .IW    (IW),
      .LW    (LW)
    ) uNext (
      .oldData(regData[r]),
      .oldLen (regLen[r]),
      .vwHit  (vwHit),
      .vwData (vwData),
      .vwMask (vwMask),
      .vwLenEn(vwLenEn),
      .vwLen  (vwLen),
      .swHit  (swHit),
      .swInd  (swInd),
      .swData (swData),
      .newData(nextData[r]),
      .newLen (nextLen[r])
    );

    // With bypass the read side sees the post-commit value from the same merge logic.
    assign viewData[r] = (BYPASS != 0) ? nextData[r] : regData[r];
    assign viewLen[r]  = (BYPASS != 0) ? nextLen[r]  : regLen[r];
  end

  // Pending bits: a set in the same cycle as a clear on that register wins.
  always_comb begin
    busyNext = busyReg;
    for (int r = 0; r < NREGS; r++) begin
      if (busyClr && (int'(busyClrAddr) == r)) busyNext[r] = 1'b0;
      if (busySet && (int'(busySetAddr) == r)) busyNext[r] = 1'b1;
    end
  end

  // Commit all register state at the clock edge; reset clears everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NREGS; r++) begin
        regData[r] <= '0;
        regLen[r]  <= '0;
      end
      busyReg <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        regData[r] <= nextData[r];
        regLen[r]  <= nextLen[r];
      end
      busyReg <= busyNext;
    end
  end

  // Combinational read ports; unused addresses and out-of-range elements read as zero.
  always_comb begin
    rData0 = '0;
    rLen0  = '0;
    rData1 = '0;
    rLen1  = '0;
    rData2 = '0;
    sel2   = '0;
    if (int'(rAddr0) < NREGS) begin
      rData0 = viewData[rAddr0];
      rLen0  = viewLen[rAddr0];
    end
    if (int'(rAddr1) < NREGS) begin
      rData1 = viewData[rAddr1];
      rLen1  = viewLen[rAddr1];
    end
    if (int'(rAddr2) < NREGS) begin
      sel2 = viewData[rAddr2];
    end
    if (int'(rInd2) < NELEMS) begin
      rData2 = sel2[int'(rInd2)*EW +: EW];
    end
  end

  assign busy = busyReg;

endmodule

// File: tb/tb_vreg_file.sv
// tb/tb_vreg_file.sv - self-checking bench for vreg_file, unbypassed 16-element and bypassed 12-element instances
module tb_vreg_file;

  localparam int NR = 16;
  localparam int NA = 16;
  localparam int NB = 12;
  localparam int EW = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [3:0]  rAddr0, rAddr1, rAddr2, rInd2;
  logic        vwEn, vwLenEn, swEn, busySet, busyClr;
  logic [3:0]  vwAddr, swAddr, swInd, busySetAddr, busyClrAddr;
  logic [15:0] vwElem [NA];
  logic [15:0] vwMask;
  logic [4:0]  vwLen;
  logic [15:0] swData;

  logic [NA*EW-1:0] vwDataA;
  logic [NB*EW-1:0] vwDataB;

  always_comb begin
    vwDataA = '0;
    vwDataB = '0;
    for (int i = 0; i < NA; i++) vwDataA[i*EW +: EW] = vwElem[i];
    for (int i = 0; i < NB; i++) vwDataB[i*EW +: EW] = vwElem[i];
  end

  logic [NA*EW-1:0] rData0A, rData1A;
  logic [4:0]       rLen0A, rLen1A;
  logic [15:0]      rData2A, busyA;
  logic [NB*EW-1:0] rData0B, rData1B;
  logic [3:0]       rLen0B, rLen1B;
  logic [15:0]      rData2B, busyB;

  vreg_file #(.NREGS(NR), .NELEMS(NA), .EW(EW), .BYPASS(0)) dutA (
    .clk(clk), .reset(reset),
    .rAddr0(rAddr0), .rData0(rData0A), .rLen0(rLen0A),
    .rAddr1(rAddr1), .rData1(rData1A), .rLen1(rLen1A),
    .rAddr2(rAddr2), .rInd2(rInd2), .rData2(rData2A),
    .vwEn(vwEn), .vwAddr(vwAddr), .vwData(vwDataA), .vwMask(vwMask),
    .vwLenEn(vwLenEn), .vwLen(vwLen),
    .swEn(swEn), .swAddr(swAddr), .swInd(swInd), .swData(swData),
    .busySet(busySet), .busySetAddr(busySetAddr),
    .busyClr(busyClr), .busyClrAddr(busyClrAddr), .busy(busyA)
  );

  vreg_file #(.NREGS(NR), .NELEMS(NB), .EW(EW), .BYPASS(1)) dutB (
    .clk(clk), .reset(reset),
    .rAddr0(rAddr0), .rData0(rData0B), .rLen0(rLen0B),
    .rAddr1(rAddr1), .rData1(rData1B), .rLen1(rLen1B),
    .rAddr2(rAddr2), .rInd2(rInd2), .rData2(rData2B),
    .vwEn(vwEn), .vwAddr(vwAddr), .vwData(vwDataB), .vwMask(vwMask[NB-1:0]),
    .vwLenEn(vwLenEn), .vwLen(vwLen[3:0]),
    .swEn(swEn), .swAddr(swAddr), .swInd(swInd), .swData(swData),
    .busySet(busySet), .busySetAddr(busySetAddr),
    .busyClr(busyClr), .busyClrAddr(busyClrAddr), .busy(busyB)
  );

  int nChecks = 0;
  int nFails  = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Model: element values, lengths and busy bits as plain integers per instance (0=A, 1=B).
  int          cur    [2][NR][NA];
  int          curLen [2][NR];
  int          nxt    [2][NR][NA];
  int          nxtLen [2][NR];
  logic [15:0] curBusy, nxtBusy;
  bit          valid = 0;

  function automatic void computeNext();
    int ne, l, s;
    for (int k = 0; k < 2; k++) begin
      ne = (k == 0) ? NA : NB;
      for (int r = 0; r < NR; r++) begin
        for (int i = 0; i < NA; i++) nxt[k][r][i] = cur[k][r][i];
        nxtLen[k][r] = curLen[k][r];
        if (vwEn && int'(vwAddr) == r) begin
          for (int i = 0; i < ne; i++) if (vwMask[i]) nxt[k][r][i] = int'(vwElem[i]);
          if (vwLenEn) begin
            l = (k == 0) ? int'(vwLen) : int'(vwLen) % 16;
            nxtLen[k][r] = (l > ne) ? ne : l;
          end
        end
        s = int'(swInd);
        if (swEn && int'(swAddr) == r && s < ne) begin
          nxt[k][r][s] = int'(swData);
          if (nxtLen[k][r] < s + 1) nxtLen[k][r] = s + 1;
        end
      end
    end
    nxtBusy = curBusy;
    if (busyClr) nxtBusy[busyClrAddr] = 1'b0;
    if (busySet) nxtBusy[busySetAddr] = 1'b1;
  endfunction

  function automatic logic [255:0] expVec(input int k, input bit post, input int r);
    logic [255:0] v;
    int ne;
    v  = '0;
    ne = (k == 0) ? NA : NB;
    for (int i = 0; i < ne; i++) v[i*16 +: 16] = 16'(post ? nxt[k][r][i] : cur[k][r][i]);
    return v;
  endfunction

  function automatic int expLen(input int k, input bit post, input int r);
    return post ? nxtLen[k][r] : curLen[k][r];
  endfunction

  function automatic int expElem(input int k, input bit post, input int r, input int ind);
    int ne;
    ne = (k == 0) ? NA : NB;
    if (ind >= ne) return 0;
    return post ? nxt[k][r][ind] : cur[k][r][ind];
  endfunction

  // Model commit at each edge.
  always @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < 2; k++)
        for (int r = 0; r < NR; r++) begin
          for (int i = 0; i < NA; i++) cur[k][r][i] = 0;
          curLen[k][r] = 0;
        end
      curBusy = '0;
      valid   = 1;
    end else if (valid) begin
      cur     = nxt;
      curLen  = nxtLen;
      curBusy = nxtBusy;
    end
  end

  // Per-cycle compare: A shows committed state, B shows post-commit state; busy is never bypassed.
  always @(negedge clk) begin
    computeNext();
    if (valid && !reset) begin
      chk("A.rData0", rData0A, expVec(0, 0, int'(rAddr0)));
      chk("A.rLen0",  rLen0A,  expLen(0, 0, int'(rAddr0)));
      chk("A.rData1", rData1A, expVec(0, 0, int'(rAddr1)));
      chk("A.rLen1",  rLen1A,  expLen(0, 0, int'(rAddr1)));
      chk("A.rData2", rData2A, expElem(0, 0, int'(rAddr2), int'(rInd2)));
      chk("A.busy",   busyA,   curBusy);
      chk("B.rData0", rData0B, expVec(1, 1, int'(rAddr0)));
      chk("B.rLen0",  rLen0B,  expLen(1, 1, int'(rAddr0)));
      chk("B.rData1", rData1B, expVec(1, 1, int'(rAddr1)));
      chk("B.rLen1",  rLen1B,  expLen(1, 1, int'(rAddr1)));
      chk("B.rData2", rData2B, expElem(1, 1, int'(rAddr2), int'(rInd2)));
      chk("B.busy",   busyB,   curBusy);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    vwEn = 0; vwLenEn = 0; swEn = 0; busySet = 0; busyClr = 0;
    vwAddr = 0; swAddr = 0; swInd = 0; swData = 0; vwLen = 0; vwMask = 0;
    busySetAddr = 0; busyClrAddr = 0;
    for (int i = 0; i < NA; i++) vwElem[i] = 16'h0;
  endtask

  task automatic vw(input int a, input logic [15:0] m, input logic [15:0] d,
                    input bit le, input int l);
    vwEn = 1; vwAddr = 4'(a); vwMask = m; vwLenEn = le; vwLen = 5'(l);
    for (int i = 0; i < NA; i++) vwElem[i] = d;
  endtask

  task automatic sw(input int a, input int ind, input logic [15:0] d);
    swEn = 1; swAddr = 4'(a); swInd = 4'(ind); swData = d;
  endtask

  logic [255:0] e;

  initial begin
    reset = 1;
    rAddr0 = 0; rAddr1 = 0; rAddr2 = 0; rInd2 = 0;
    idle();
    tick(); tick();
    reset = 0;
    chk("lit.reset.busy", busyA, 0);
    chk("lit.reset.len",  rLen0A, 0);

    // Reset clears written state and busy; a write in the reset cycle is dropped.
    vw(3, 16'hFFFF, 16'hFFFF, 1, 16);
    busySet = 1; busySetAddr = 2;
    tick(); idle();
    rAddr0 = 3;
    #1;
    chk("lit.r3.data", rData0A, {NA*EW{1'b1}});
    chk("lit.r3.len",  rLen0A, 16);
    chk("lit.busy2",   busyA, 16'h0004);
    reset = 1;
    vw(4, 16'hFFFF, 16'h1234, 1, 5);
    tick(); idle();
    reset = 0;
    rAddr1 = 4;
    #1;
    chk("lit.rst.data", rData0A, 0);
    chk("lit.rst.len",  rLen0A, 0);
    chk("lit.rst.busy", busyA, 0);
    chk("lit.rst.drop", rData1A, 0);
    tick();

    // Masked write merges only elements 4..7; length left alone.
    vw(2, 16'hFFFF, 16'h1111, 1, 3);
    tick();
    vw(2, 16'h00F0, 16'hABCD, 0, 0);
    tick(); idle();
    rAddr0 = 2;
    #1;
    e = '0;
    for (int i = 0; i < 16; i++) e[i*16 +: 16] = (i >= 4 && i <= 7) ? 16'hABCD : 16'h1111;
    chk("lit.mask.data", rData0A, e);
    chk("lit.mask.len",  rLen0A, 3);
    tick();

    // Collision on r5: element write wins at index 9, length grows to 10.
    vw(5, 16'hFFFF, 16'h2222, 1, 4);
    sw(5, 9, 16'h7777);
    rAddr0 = 5; rAddr2 = 5; rInd2 = 9;
    #1;
    chk("lit.coll.lenB", rLen0B, 10);
    chk("lit.coll.eB",   rData2B, 16'h7777);
    tick(); idle();
    #1;
    chk("lit.coll.lenA", rLen0A, 10);
    chk("lit.coll.e9A",  rData2A, 16'h7777);
    rInd2 = 8;
    #1;
    chk("lit.coll.e8A",  rData2A, 16'h2222);
    tick();

    // Latency: A shows old value in the write cycle, B shows the new one.
    sw(1, 0, 16'h55AA);
    rAddr2 = 1; rInd2 = 0;
    #1;
    chk("lit.lat.oldA", rData2A, 16'h0000);
    chk("lit.lat.newB", rData2B, 16'h55AA);
    tick(); idle();
    #1;
    chk("lit.lat.nextA", rData2A, 16'h55AA);

    // Busy: set beats clear; a lone clear lands one cycle later.
    busySet = 1; busySetAddr = 7; busyClr = 1; busyClrAddr = 7;
    tick(); idle();
    #1;
    chk("lit.busy.set", busyA[7], 1);
    busyClr = 1; busyClrAddr = 7;
    #1;
    chk("lit.busy.hold", busyA[7], 1);
    tick(); idle();
    #1;
    chk("lit.busy.clr", busyA[7], 0);

    // Bounds on the 12-element instance.
    vw(6, 16'hFFFF, 16'h3333, 1, 15);
    tick(); idle();
    rAddr0 = 6; rAddr2 = 6; rInd2 = 13;
    #1;
    chk("lit.clamp.B", rLen0B, 12);
    chk("lit.clamp.A", rLen0A, 15);
    sw(6, 13, 16'h9999);
    #1;
    chk("lit.oob.lenB",  rLen0B, 12);
    chk("lit.oob.dataB", rData0B, {12{16'h3333}});
    chk("lit.oob.rdB",   rData2B, 0);
    chk("lit.oob.oldA",  rData2A, 16'h3333);
    tick(); idle();
    #1;
    chk("lit.oob.newA", rData2A, 16'h9999);
    rInd2 = 14;
    #1;
    chk("lit.oob14.B", rData2B, 0);
    chk("lit.oob14.A", rData2A, 16'h3333);
    tick();

    // Mixed directed patterns, checked by the model every cycle.
    for (int n = 0; n < 40; n++) begin
      idle();
      if (n % 3 == 0) vw((n * 3) % 16, 16'(16'h0101 << (n % 8)), 16'(n * 16'h0123), n % 4 == 0, (n * 7) % 32);
      if (n % 2 == 0) sw((n * 5) % 16, (n * 7) % 16, 16'(16'hC000 + n));
      if (n % 5 == 1) begin busySet = 1; busySetAddr = 4'(n % 16); end
      if (n % 4 == 2) begin busyClr = 1; busyClrAddr = 4'((n + 15) % 16); end
      rAddr0 = 4'((n * 3) % 16); rAddr1 = 4'((n * 5) % 16);
      rAddr2 = 4'((n * 5) % 16); rInd2 = 4'((n * 7) % 16);
      tick();
    end
    idle();
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
